// File: rtl/uart_tx_param.sv
// UART transmitter with a clock-enable baud timer on the system clock.
// Runtime divisor, parity mode, stop-bit count and line-break generation.
// One frame is sent per word accepted on the data_valid/data_ready handshake.
module uart_tx_param #(
  parameter int DATA_SIZE  = 8,
  parameter int DVSR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DVSR_WIDTH-1:0] baud_dvsr,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits,
  input  logic [DATA_SIZE-1:0]  data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  break_req,
  output logic                  serial_data_out,
  output logic                  tx_busy,
  output logic                  tx_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_BRK_STOP
  } state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_SIZE - 1);

  state_t                state_q, state_d;
  logic [DVSR_WIDTH-1:0] tmr_q, tmr_d;
  logic [DVSR_WIDTH-1:0] dvsr_q, dvsr_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_SIZE-1:0]  shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  stop_q, stop_d;
  logic                  line_q, line_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_end;

  // Even mode sends the XOR of the data bits, odd mode its inverse.
  function automatic logic parity_of(input logic [DATA_SIZE-1:0] d,
                                     input logic [1:0] mode);
    return (mode == 2'b10) ? ~(^d) : (^d);
  endfunction

  // Next-state, timer, bit counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    dvsr_d    = dvsr_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop_d    = stop_q;
    done_d    = 1'b0;
    line_d    = 1'b1;
    bit_end   = (tmr_q == dvsr_q);

    // The timer only runs outside IDLE; it wraps at the end of each bit.
    if (state_q != S_IDLE) tmr_d = bit_end ? '0 : tmr_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        bit_d = '0;
        // ready_q gates acceptance so nothing is taken in the cycle
        // right after reset release, when data_ready is still low.
        if (ready_q) begin
          if (break_req) begin
            dvsr_d  = baud_dvsr;
            state_d = S_BREAK;
          end else if (data_valid) begin
            dvsr_d    = baud_dvsr;
            shift_d   = data_in;
            par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_d = parity_of(data_in, parity_mode);
            stop_d    = stop_bits;
            state_d   = S_START;
          end
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == {3'b000, stop_q}) begin
            bit_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (bit_end && !break_req) state_d = S_BRK_STOP;
      end
      S_BRK_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
      S_PARITY: line_d = par_bit_q;
      S_BREAK:  line_d = 1'b0;
      default:  line_d = 1'b1;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; only control state is reset.
  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    par_bit_q <= par_bit_d;
    if (!reset_n) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      dvsr_q   <= '0;
      bit_q    <= '0;
      par_en_q <= 1'b0;
      stop_q   <= 1'b0;
      line_q   <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      dvsr_q   <= dvsr_d;
      bit_q    <= bit_d;
      par_en_q <= par_en_d;
      stop_q   <= stop_d;
      line_q   <= line_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign serial_data_out = line_q;
  assign data_ready      = ready_q;
  assign tx_busy         = busy_q;
  assign tx_done         = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed testbench for uart_tx_param (DATA_SIZE=8, DVSR_WIDTH=16).
module tb_uart_tx_param;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] baud_dvsr;
  logic [1:0]  parity_mode;
  logic        stop_bits;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic        break_req;
  logic        serial_data_out;
  logic        tx_busy;
  logic        tx_done;

  int total = 0;
  int bad   = 0;

  logic ln [0:79];
  logic dn [0:79];
  logic rd [0:79];
  logic bz [0:79];

  uart_tx_param #(.DATA_SIZE(8), .DVSR_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .baud_dvsr(baud_dvsr),
    .parity_mode(parity_mode), .stop_bits(stop_bits), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .break_req(break_req),
    .serial_data_out(serial_data_out), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Records outputs for cycles 1..n; at cycle vd drops data_valid, at bd
  // drops break_req, at ca switches to even parity and divisor 0.
  task automatic capture(input int n, input int vd, input int bd, input int ca);
    for (int k = 1; k <= n; k++) begin
      if (k == vd) data_valid = 1'b0;
      if (k == bd) break_req = 1'b0;
      if (k == ca) begin
        parity_mode = 2'b01;
        baud_dvsr   = 16'd0;
      end
      ln[k] = serial_data_out;
      dn[k] = tx_done;
      rd[k] = data_ready;
      bz[k] = tx_busy;
      step();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(data_ready === 1'b1 && tx_busy === 1'b0) && n < 300) begin
      step();
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL wait_idle: data_ready=%b tx_busy=%b, required idle within 300 cycles",
               data_ready, tx_busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; baud_dvsr = 16'd3; parity_mode = 2'b00; stop_bits = 1'b0;
    data_in = 8'h00; data_valid = 1'b0; break_req = 1'b0;
    step(); step();
    total++; if (serial_data_out !== 1'b1) begin bad++; $display("FAIL reset_line: got %b want 1", serial_data_out); end
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", data_ready); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", tx_done); end
    reset_n = 1'b1;
    step();
    total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release: got %b want 1", data_ready); end
  endtask

  // 0xB3, dvsr=3, no parity, one stop bit: 10 bits of 4 cycles.
  task automatic test_basic_frame();
    logic [9:0] exp_bits;
    int ndone;
    exp_bits = 10'b0110011011;  // bit 9 = start bit, sent first
    wait_idle();
    baud_dvsr = 16'd3; parity_mode = 2'b00; stop_bits = 1'b0;
    data_in = 8'hB3; data_valid = 1'b1;
    step();
    capture(45, 1, 0, 0);
    for (int b = 0; b < 10; b++) begin
      for (int c = 1; c <= 4; c++) begin
        total++;
        if (ln[4*b+c] !== exp_bits[9-b]) begin
          bad++;
          $display("FAIL basic_line bit%0d cyc%0d: got %b want %b", b, 4*b+c, ln[4*b+c], exp_bits[9-b]);
        end
      end
    end
    ndone = 0;
    for (int k = 1; k <= 45; k++) if (dn[k] === 1'b1) ndone++;
    total++; if (ndone !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", ndone); end
    total++; if (dn[41] !== 1'b1) begin bad++; $display("FAIL basic_done_41: got %b want 1", dn[41]); end
    for (int k = 1; k <= 40; k++) begin
      total++; if (rd[k] !== 1'b0) begin bad++; $display("FAIL basic_ready cyc%0d: got %b want 0", k, rd[k]); end
    end
    total++; if (rd[41] !== 1'b1) begin bad++; $display("FAIL basic_ready_41: got %b want 1", rd[41]); end
    total++; if (bz[1] !== 1'b1) begin bad++; $display("FAIL basic_busy_1: got %b want 1", bz[1]); end
    total++; if (bz[41] !== 1'b0) begin bad++; $display("FAIL basic_busy_41: got %b want 0", bz[41]); end
  endtask

  // 0xB3 with two stop bits and even, then odd parity.
  task automatic test_parity();
    logic [1:0] modes [2];
    logic       pexp  [2];
    modes[0] = 2'b01; pexp[0] = 1'b1;
    modes[1] = 2'b10; pexp[1] = 1'b0;
    for (int m = 0; m < 2; m++) begin
      wait_idle();
      baud_dvsr = 16'd3; parity_mode = modes[m]; stop_bits = 1'b1;
      data_in = 8'hB3; data_valid = 1'b1;
      step();
      capture(52, 1, 0, 0);
      for (int k = 37; k <= 40; k++) begin
        total++; if (ln[k] !== pexp[m]) begin bad++; $display("FAIL parity_bit mode%0d cyc%0d: got %b want %b", m, k, ln[k], pexp[m]); end
      end
      for (int k = 41; k <= 48; k++) begin
        total++; if (ln[k] !== 1'b1) begin bad++; $display("FAIL parity_stop mode%0d cyc%0d: got %b want 1", m, k, ln[k]); end
      end
      total++; if (bz[48] !== 1'b1) begin bad++; $display("FAIL parity_busy_48 mode%0d: got %b want 1", m, bz[48]); end
      total++; if (dn[48] !== 1'b0) begin bad++; $display("FAIL parity_done_48 mode%0d: got %b want 0", m, dn[48]); end
      total++; if (dn[49] !== 1'b1) begin bad++; $display("FAIL parity_done_49 mode%0d: got %b want 1", m, dn[49]); end
    end
  endtask

  // 0x5C then 0xAE with data_valid held, dvsr=0.
  task automatic test_back_to_back();
    logic [9:0] f1, f2;
    int ndone;
    f1 = 10'b0001110101;
    f2 = 10'b0011101011;
    wait_idle();
    baud_dvsr = 16'd0; parity_mode = 2'b00; stop_bits = 1'b0;
    data_in = 8'h5C; data_valid = 1'b1;
    step();
    data_in = 8'hAE;
    capture(26, 12, 0, 0);
    for (int b = 0; b < 10; b++) begin
      total++; if (ln[1+b] !== f1[9-b]) begin bad++; $display("FAIL b2b_f1 cyc%0d: got %b want %b", 1+b, ln[1+b], f1[9-b]); end
      total++; if (ln[12+b] !== f2[9-b]) begin bad++; $display("FAIL b2b_f2 cyc%0d: got %b want %b", 12+b, ln[12+b], f2[9-b]); end
    end
    total++; if (ln[11] !== 1'b1) begin bad++; $display("FAIL b2b_gap_line: got %b want 1", ln[11]); end
    total++; if (rd[11] !== 1'b1) begin bad++; $display("FAIL b2b_gap_ready: got %b want 1", rd[11]); end
    total++; if (rd[12] !== 1'b0) begin bad++; $display("FAIL b2b_ready_12: got %b want 0", rd[12]); end
    total++; if (dn[11] !== 1'b1) begin bad++; $display("FAIL b2b_done_11: got %b want 1", dn[11]); end
    total++; if (dn[22] !== 1'b1) begin bad++; $display("FAIL b2b_done_22: got %b want 1", dn[22]); end
    ndone = 0;
    for (int k = 1; k <= 26; k++) if (dn[k] === 1'b1) ndone++;
    total++; if (ndone !== 2) begin bad++; $display("FAIL b2b_done_count: got %0d want 2", ndone); end
  endtask

  task automatic test_break();
    logic [9:0] fb;
    fb = 10'b0110011011;
    // Short break request: minimum one bit low, then one bit high.
    wait_idle();
    baud_dvsr = 16'd3; break_req = 1'b1;
    step();
    capture(12, 0, 2, 0);
    for (int k = 1; k <= 8; k++) begin
      total++; if (ln[k] !== (k > 4)) begin bad++; $display("FAIL brk_line cyc%0d: got %b want %b", k, ln[k], (k > 4)); end
      total++; if (rd[k] !== 1'b0) begin bad++; $display("FAIL brk_ready cyc%0d: got %b want 0", k, rd[k]); end
    end
    total++; if (rd[9] !== 1'b1) begin bad++; $display("FAIL brk_ready_9: got %b want 1", rd[9]); end
    for (int k = 1; k <= 12; k++) begin
      total++; if (dn[k] !== 1'b0) begin bad++; $display("FAIL brk_done cyc%0d: got %b want 0", k, dn[k]); end
    end
    // Break and data together: break first, word after BRK_STOP.
    wait_idle();
    baud_dvsr = 16'd3; parity_mode = 2'b00; stop_bits = 1'b0;
    data_in = 8'hB3; data_valid = 1'b1; break_req = 1'b1;
    step();
    capture(52, 10, 2, 0);
    for (int k = 1; k <= 9; k++) begin
      total++; if (ln[k] !== (k > 4)) begin bad++; $display("FAIL brkdat_line cyc%0d: got %b want %b", k, ln[k], (k > 4)); end
    end
    for (int b = 0; b < 10; b++) begin
      total++; if (ln[10+4*b] !== fb[9-b]) begin bad++; $display("FAIL brkdat_frame bit%0d: got %b want %b", b, ln[10+4*b], fb[9-b]); end
    end
    total++; if (dn[49] !== 1'b0) begin bad++; $display("FAIL brkdat_done_49: got %b want 0", dn[49]); end
    total++; if (dn[50] !== 1'b1) begin bad++; $display("FAIL brkdat_done_50: got %b want 1", dn[50]); end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] f;
    f = 10'b0111100001;
    wait_idle();
    baud_dvsr = 16'd3; parity_mode = 2'b00; stop_bits = 1'b0;
    data_in = 8'h00; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    for (int k = 1; k < 18; k++) step();
    // Cycle 18 lies inside data bit 3 (cycles 17..20), line low.
    total++; if (serial_data_out !== 1'b0) begin bad++; $display("FAIL mid_line_before: got %b want 0", serial_data_out); end
    reset_n = 1'b0;
    step();
    total++; if (serial_data_out !== 1'b1) begin bad++; $display("FAIL mid_line_after_rst: got %b want 1", serial_data_out); end
    total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after_rst: got %b want 0", tx_busy); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL mid_done_after_rst: got %b want 0", tx_done); end
    reset_n = 1'b1;
    step();
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL mid_done_release: got %b want 0", tx_done); end
    wait_idle();
    data_in = 8'h0F; data_valid = 1'b1;
    step();
    capture(42, 1, 0, 0);
    for (int b = 0; b < 10; b++) begin
      total++; if (ln[4*b+2] !== f[9-b]) begin bad++; $display("FAIL mid_0F bit%0d: got %b want %b", b, ln[4*b+2], f[9-b]); end
    end
    total++; if (dn[41] !== 1'b1) begin bad++; $display("FAIL mid_0F_done: got %b want 1", dn[41]); end
  endtask

  task automatic test_config_change();
    logic [9:0] fa;
    logic [10:0] fe;
    fa = 10'b0110011011;
    fe = 11'b01100110111;  // 0xB3 with even parity 1, then stop
    wait_idle();
    baud_dvsr = 16'd1; parity_mode = 2'b00; stop_bits = 1'b0;
    data_in = 8'hB3; data_valid = 1'b1;
    step();
    capture(24, 1, 0, 8);
    for (int b = 0; b < 10; b++) begin
      total++; if (ln[2*b+2] !== fa[9-b]) begin bad++; $display("FAIL cfg_old bit%0d: got %b want %b", b, ln[2*b+2], fa[9-b]); end
    end
    total++; if (dn[20] !== 1'b0) begin bad++; $display("FAIL cfg_old_done_20: got %b want 0", dn[20]); end
    total++; if (dn[21] !== 1'b1) begin bad++; $display("FAIL cfg_old_done_21: got %b want 1", dn[21]); end
    wait_idle();
    data_valid = 1'b1;
    step();
    capture(14, 1, 0, 0);
    for (int b = 0; b < 11; b++) begin
      total++; if (ln[1+b] !== fe[10-b]) begin bad++; $display("FAIL cfg_new bit%0d: got %b want %b", b, ln[1+b], fe[10-b]); end
    end
    total++; if (dn[12] !== 1'b1) begin bad++; $display("FAIL cfg_new_done_12: got %b want 1", dn[12]); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity();
    test_back_to_back();
    test_break();
    test_reset_midframe();
    test_config_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
